// File: rtl/time_keeper.sv
// Time-of-day keeper: prescales clk down to 1 s ticks and keeps HH:MM:SS in BCD,
// with a set mode that bumps one field at a time for the front-panel buttons.
`ifndef KILO
`define KILO 1000
`endif

module time_keeper #(
  parameter int CLK_FREQ_HZ = `KILO
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        set_en,
  input  logic [1:0]  set_sel,
  input  logic        inc,
  output logic [31:0] time_bcd,
  output logic        sec_pulse,
  output logic        day_pulse
);

  localparam int            CW      = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_FREQ_HZ - 1);

  localparam logic [7:0] SEC_TOP = 8'h59;
  localparam logic [7:0] MIN_TOP = 8'h59;
  localparam logic [7:0] HR_TOP  = 8'h23;

  localparam logic [1:0] SEL_SEC = 2'd0;
  localparam logic [1:0] SEL_MIN = 2'd1;
  localparam logic [1:0] SEL_HR  = 2'd2;

  logic [CW-1:0] cnt;
  logic [7:0]    sec_bcd;
  logic [7:0]    min_bcd;
  logic [7:0]    hr_bcd;
  logic          tick;
  logic          sec_wrap;
  logic          min_wrap;
  logic          day_wrap;

  // Two-digit BCD increment that wraps to 00 after reaching top.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    logic [7:0] r;
    if (v == top)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'h0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign tick     = (cnt == CNT_MAX) && run && !set_en;
  assign sec_wrap = (sec_bcd == SEC_TOP);
  assign min_wrap = sec_wrap && (min_bcd == MIN_TOP);
  assign day_wrap = min_wrap && (hr_bcd == HR_TOP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      sec_bcd   <= 8'h00;
      min_bcd   <= 8'h00;
      hr_bcd    <= 8'h00;
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
    end else begin
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
      if (set_en) begin
        // Holding the prescaler at zero makes the first tick land a full second after set ends.
        cnt <= '0;
        if (inc) begin
          case (set_sel)
            SEL_SEC: sec_bcd <= bcd_inc(sec_bcd, SEC_TOP);
            SEL_MIN: min_bcd <= bcd_inc(min_bcd, MIN_TOP);
            SEL_HR:  hr_bcd  <= bcd_inc(hr_bcd, HR_TOP);
            default: ;
          endcase
        end
      end else if (run) begin
        if (tick) begin
          cnt       <= '0;
          sec_pulse <= 1'b1;
          day_pulse <= day_wrap;
          sec_bcd   <= bcd_inc(sec_bcd, SEC_TOP);
          if (sec_wrap) min_bcd <= bcd_inc(min_bcd, MIN_TOP);
          if (min_wrap) hr_bcd  <= bcd_inc(hr_bcd, HR_TOP);
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign time_bcd = {hr_bcd, 4'hF, min_bcd, 4'hF, sec_bcd};

endmodule
